game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
- Top-level sequencer for the pipe-dodging game.
- Owns the game state machine (IDLE/PLAY/OVER) and generates the frame tick that paces bird and pipe motion.
- Samples the collision checker's hit level on ticks, detects pipes passing the bird for scoring, and holds current and best BCD scores.
- Sits between the button input, the position/motion blocks and the VGA/seven-segment display blocks.

Parameters:
- TICK_DIV, 1000000: clocks per frame tick (count range 0..TICK_DIV-1).
- OVER_HOLD, 60: frame ticks spent in OVER before a restart is accepted.
- Y_FLOOR, 12'd460: bird y at or beyond this value counts as a floor collision.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn_start  in  1  raw start/flap button level (asynchronous to clk)
- hit  in  1  collision level from the pipe collision checker
- bpos_x  in  12  bird x position
- bpos_y  in  12  bird y position
- pippos_x1, pippos_x2, pippos_x3  in  12 each  pipe x positions
- state  out  2  0=IDLE, 1=PLAY, 2=OVER
- run_en  out  1  high only in PLAY; motion blocks advance only when high
- frame_tick  out  1  one-clock pulse every TICK_DIV clocks, in all states
- restart  out  1  one-clock pulse; motion blocks reload initial positions
- flap  out  1  one-clock pulse; bird velocity kick
- game_over  out  1  high in OVER
- score  out  16  4-digit BCD current score
- best  out  16  4-digit BCD high score

Behaviour:
- Reset (async, any time): state=IDLE. tick counter=0. score=0, best=0. All pulses=0. Button synchroniser=0. prev_x regs=0. hold count=0.
- Button input: 2-flop synchroniser, then rising-edge detect. The edge (btn_edge) appears 3 clocks after the raw rise.
- Tick counter:
  - Free-running in all states.
  - frame_tick=1 in the cycle where count==TICK_DIV-1; count then wraps to 0.
- IDLE:
  - run_en=0.
  - On btn_edge: restart=1 for that cycle, score<=0, prev_x_i<=pippos_x_i, next state PLAY.
- PLAY:
  - run_en=1.
  - btn_edge gives flap=1 for that cycle. flap is never asserted outside PLAY.
  - On frame_tick: if hit==1 or bpos_y>=Y_FLOOR, go to OVER. Otherwise evaluate passes.
  - Collision has priority over passes in the same tick: no score is added on the fatal tick.
- Pass rule (per pipe i, tick only): pass_i = (prev_x_i > bpos_x) && (pippos_x_i <= bpos_x), unsigned 12-bit compare.
  - prev_x_i<=pippos_x_i on every PLAY tick.
  - A pipe wrapping from small x to large x never counts.
  - Multiple passes in one tick add their count (0..3).
- Score arithmetic: BCD add with per-digit carry. Saturates at 16'h9999; further passes leave it unchanged.
- Entering OVER (registered on the transition clock):
  - game_over=1, run_en=0, hold count=0.
  - If score>best then best<=score, compared as BCD, which orders identically to unsigned binary.
- OVER:
  - Hold count increments on each frame_tick, saturating at OVER_HOLD.
  - btn_edge is ignored while hold<OVER_HOLD.
  - When hold==OVER_HOLD and btn_edge occurs: same actions as the IDLE start (restart pulse, score clear, prev_x load), then go to PLAY, game_over=0.
- Latency:
  - State, score and best update on the clock edge after the qualifying tick/edge cycle.
  - restart and flap are combinational from registered state and btn_edge, and are aligned to the transition cycle.
- Simultaneous events:
  - btn_edge and frame_tick in the same PLAY cycle: flap=1 and the tick evaluation both occur.
  - If that tick collides: flap still pulses, but state becomes OVER.
- hit is ignored outside PLAY ticks. Levels between ticks are not latched.

Decomposition:
- Shared package game_pkg:
  - State encodings ST_IDLE/ST_PLAY/ST_OVER.
  - Screen constants (Y_FLOOR default, bird/pipe widths).
  - BCD_MAX=16'h9999.
- One natural sub-module: bcd_add_sat — 4-digit BCD plus 0..3 with saturation. Combinational; instantiated once for score.

Test Plan (TICK_DIV=4, OVER_HOLD=3):
- Reset mid-PLAY with score=0x0012 -> state=0, score=0, best=0, run_en=0 immediately, with no clock edge.
- Button rise in IDLE -> restart=1 for exactly one cycle, 3 clocks later; state=1 next cycle; frame_tick every 4 clocks.
- PLAY, bpos_x=100, pipe1 prev 101 -> 100 on tick, pipes 2/3 at 300 -> score 0x0001. Same tick with pipes 1 and 2 both crossing -> +2. Pipe wrap 5->400 -> no change.
- score=0x0099 plus 1 pass -> 0x0100. score=0x9999 plus 2 passes -> 0x9999.
- hit=1 on tick that also has a pass, score=0x0007, best=0x0005 -> state=2, score stays 0x0007, best=0x0007, game_over=1. hit=1 between ticks only -> no effect.
- OVER: button edge after 2 ticks -> ignored. Edge after 3 ticks -> restart pulse, score=0, state=1, best kept. bpos_y=460 on a tick -> OVER.

Source files
------------

// File: rtl/game_pkg.sv
// Shared encodings and screen constants for the pipe-dodging game.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam logic [11:0] Y_FLOOR_DEF = 12'd460;
    localparam logic [11:0] BIRD_W      = 12'd16;
    localparam logic [11:0] PIPE_W      = 12'd40;
    localparam logic [15:0] BCD_MAX     = 16'h9999;

endpackage

// File: rtl/bcd_add_sat.sv
// 4-digit BCD plus 0..3 with saturation at 9999; purely combinational.
module bcd_add_sat
    import game_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [1:0]  inc_i,
    output logic [15:0] sum_o
);

    logic [15:0] sum_raw;
    logic [4:0]  carry;
    logic [4:0]  dig;

    always_comb begin
        sum_raw = '0;
        carry   = {3'b000, inc_i};
        dig     = '0;
        for (int i = 0; i < 4; i++) begin
            dig = {1'b0, a_i[4*i +: 4]} + carry;
            if (dig > 5'd9) begin
                sum_raw[4*i +: 4] = 4'(dig - 5'd10);
                carry             = 5'd1;
            end else begin
                sum_raw[4*i +: 4] = dig[3:0];
                carry             = 5'd0;
            end
        end
        // A carry out of the top digit means the true sum passed 9999.
        sum_o = (carry != 5'd0) ? BCD_MAX : sum_raw;
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: IDLE/PLAY/OVER FSM, frame tick, button edge, pass scoring and best score.
// State/score/best update one clock after the qualifying cycle; restart/flap are same-cycle pulses.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 1000000,
    parameter int unsigned OVER_HOLD = 60,
    parameter logic [11:0] Y_FLOOR   = Y_FLOOR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        hit,
    input  logic [11:0] bpos_x,
    input  logic [11:0] bpos_y,
    input  logic [11:0] pippos_x1,
    input  logic [11:0] pippos_x2,
    input  logic [11:0] pippos_x3,
    output logic [1:0]  state,
    output logic        run_en,
    output logic        frame_tick,
    output logic        restart,
    output logic        flap,
    output logic        game_over,
    output logic [15:0] score,
    output logic [15:0] best
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HW = (OVER_HOLD > 0) ? $clog2(OVER_HOLD + 1) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(OVER_HOLD);

    state_t            state_q, state_d;
    logic [CW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [15:0]       score_q, score_d;
    logic [15:0]       best_q, best_d;
    logic [2:0][11:0]  prev_x_q, prev_x_d;
    logic              btn_meta_q, btn_sync_q, btn_prev_q, btn_edge_q;

    logic [2:0][11:0]  pipe_x;
    logic [2:0]        pass;
    logic [1:0]        n_pass;
    logic [15:0]       score_inc;
    logic              collide;
    logic              btn_edge;

    assign pipe_x     = {pippos_x3, pippos_x2, pippos_x1};
    assign frame_tick = (tick_cnt_q == TICK_LAST);
    assign tick_cnt_d = frame_tick ? '0 : tick_cnt_q + CW'(1);
    assign btn_edge   = btn_edge_q;
    assign collide    = hit || (bpos_y >= Y_FLOOR);

    // A pipe counts once, on the tick its x moves from right of the bird to at/left of it.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            pass[i] = (prev_x_q[i] > bpos_x) && (pipe_x[i] <= bpos_x);
        end
        n_pass = {1'b0, pass[0]} + {1'b0, pass[1]} + {1'b0, pass[2]};
    end

    bcd_add_sat u_score_add (
        .a_i   (score_q),
        .inc_i (n_pass),
        .sum_o (score_inc)
    );

    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        best_d   = best_q;
        prev_x_d = prev_x_q;
        hold_d   = hold_q;
        restart  = 1'b0;
        flap     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_edge) begin
                    restart  = 1'b1;
                    score_d  = '0;
                    prev_x_d = pipe_x;
                    state_d  = ST_PLAY;
                end
            end
            ST_PLAY: begin
                flap = btn_edge;
                if (frame_tick) begin
                    prev_x_d = pipe_x;
                    if (collide) begin
                        state_d = ST_OVER;
                        hold_d  = '0;
                        if (score_q > best_q) begin
                            best_d = score_q;
                        end
                    end else begin
                        score_d = score_inc;
                    end
                end
            end
            ST_OVER: begin
                if (frame_tick && (hold_q < HOLD_MAX)) begin
                    hold_d = hold_q + HW'(1);
                end
                if ((hold_q == HOLD_MAX) && btn_edge) begin
                    restart  = 1'b1;
                    score_d  = '0;
                    prev_x_d = pipe_x;
                    state_d  = ST_PLAY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            hold_q     <= '0;
            score_q    <= '0;
            best_q     <= '0;
            prev_x_q   <= '0;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_prev_q <= 1'b0;
            btn_edge_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            hold_q     <= hold_d;
            score_q    <= score_d;
            best_q     <= best_d;
            prev_x_q   <= prev_x_d;
            btn_meta_q <= btn_start;
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_sync_q;
            btn_edge_q <= btn_sync_q & ~btn_prev_q;
        end
    end

    assign state     = state_q;
    assign run_en    = (state_q == ST_PLAY);
    assign game_over = (state_q == ST_OVER);
    assign score     = score_q;
    assign best      = best_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl with a fast tick (4 clocks) and short OVER hold (3 ticks).
module tb_game_flow_ctrl;

    typedef struct {
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] bs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_start = 1'b0;
    logic        hit = 1'b0;
    logic [11:0] bpos_x = 12'd100;
    logic [11:0] bpos_y = 12'd200;
    logic [11:0] p1 = 12'd300;
    logic [11:0] p2 = 12'd300;
    logic [11:0] p3 = 12'd300;
    logic [1:0]  state;
    logic        run_en, frame_tick, restart, flap, game_over;
    logic [15:0] score, best;

    exp_t        sb[$];
    exp_t        mon_e;
    bit          pend = 1'b0;
    int          n_chk = 0;
    int          n_err = 0;
    int          m_cnt = 0;
    int          m_best = 0;
    logic [11:0] m_prev [3];
    int          per;
    int          n_tk;
    bit          got;
    bit          saw;

    game_flow_ctrl #(
        .TICK_DIV  (4),
        .OVER_HOLD (3),
        .Y_FLOOR   (12'd460)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_start  (btn_start),
        .hit        (hit),
        .bpos_x     (bpos_x),
        .bpos_y     (bpos_y),
        .pippos_x1  (p1),
        .pippos_x2  (p2),
        .pippos_x3  (p3),
        .state      (state),
        .run_en     (run_en),
        .frame_tick (frame_tick),
        .restart    (restart),
        .flap       (flap),
        .game_over  (game_over),
        .score      (score),
        .best       (best)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        to_bcd = {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic m_restart();
        m_cnt     = 0;
        m_prev[0] = p1;
        m_prev[1] = p2;
        m_prev[2] = p3;
    endtask

    // Drives one PLAY tick's inputs and pushes the expected outcome of that tick.
    task automatic play_tick(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
                             input logic h, input logic [11:0] y);
        exp_t        e;
        int          np;
        bit          tk;
        logic [11:0] nx [3];
        tk = 1'b0;
        for (int i = 0; i < 20 && !tk; i++) begin
            @(negedge clk);
            if (frame_tick) tk = 1'b1;
        end
        if (!tk) begin
            chk("tick_wait", 32'(tk), 32'd1);
        end else begin
            p1 = a; p2 = b; p3 = c; hit = h; bpos_y = y;
            nx[0] = a; nx[1] = b; nx[2] = c;
            e.st = 2'd1;
            if (h || y >= 12'd460) begin
                e.st = 2'd2;
                if (m_cnt > m_best) m_best = m_cnt;
            end else begin
                np = 0;
                for (int i = 0; i < 3; i++) begin
                    if (m_prev[i] > bpos_x && nx[i] <= bpos_x) np++;
                end
                m_cnt = (m_cnt + np > 9999) ? 9999 : m_cnt + np;
            end
            for (int i = 0; i < 3; i++) m_prev[i] = nx[i];
            e.sc = to_bcd(m_cnt);
            e.bs = to_bcd(m_best);
            sb.push_back(e);
            @(posedge clk);
            #1;
            hit    = 1'b0;
            bpos_y = 12'd200;
        end
    endtask

    task automatic pump(input int pairs);
        for (int k = 0; k < pairs; k++) begin
            play_tick(12'd101, 12'd101, 12'd101, 1'b0, 12'd200);
            play_tick(12'd100, 12'd100, 12'd100, 1'b0, 12'd200);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_restart(output bit g);
        g = 1'b0;
        for (int i = 0; i < 12 && !g; i++) begin
            @(negedge clk);
            if (restart) g = 1'b1;
        end
    endtask

    task automatic restart_over();
        bit g;
        int n;
        n = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            @(negedge clk);
            if (frame_tick && game_over) n++;
        end
        chk("over_ticks", 32'(n), 32'd3);
        btn_start = 1'b1;
        wait_restart(g);
        chk("restart_seen", 32'(g), 32'd1);
        chk("restart_state", 32'(state), 32'd2);
        @(negedge clk);
        chk("restart_width", 32'(restart), 32'd0);
        chk("restart_play", 32'(state), 32'd1);
        chk("restart_score", 32'(score), 32'd0);
        btn_start = 1'b0;
        m_restart();
    endtask

    always @(negedge clk) begin
        if (pend && sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("sb_state", 32'(state), 32'(mon_e.st));
            chk("sb_score", 32'(score), 32'(mon_e.sc));
            chk("sb_best", 32'(best), 32'(mon_e.bs));
        end
        pend = frame_tick && run_en;
    end

    initial begin
        m_restart();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_best", 32'(best), 32'd0);
        chk("rst_run_en", 32'(run_en), 32'd0);
        chk("rst_pulses", 32'({restart, flap, game_over}), 32'd0);
        rst = 1'b0;

        // Start: edge appears three clocks after the raw rise.
        @(posedge clk); #1 btn_start = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("start_early", 32'(restart), 32'd0);
        @(posedge clk);
        #1 chk("start_restart", 32'(restart), 32'd1);
        chk("start_no_flap", 32'(flap), 32'd0);
        chk("start_idle", 32'(state), 32'd0);
        @(posedge clk);
        #1 chk("start_width", 32'(restart), 32'd0);
        chk("start_play", 32'(state), 32'd1);
        chk("start_run_en", 32'(run_en), 32'd1);
        btn_start = 1'b0;
        m_restart();

        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (frame_tick) got = 1'b1;
        end
        per = 0; got = 1'b0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clk);
            if (frame_tick) begin got = 1'b1; per = i; end
        end
        chk("tick_period", 32'(per), 32'd4);

        repeat (4) @(negedge clk);
        btn_start = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (flap) got = 1'b1;
        end
        chk("flap_seen", 32'(got), 32'd1);
        chk("flap_state", 32'(state), 32'd1);
        @(negedge clk);
        chk("flap_width", 32'(flap), 32'd0);
        btn_start = 1'b0;

        // Single pass, double pass, wrap.
        play_tick(12'd101, 12'd300, 12'd300, 1'b0, 12'd200);
        play_tick(12'd100, 12'd300, 12'd300, 1'b0, 12'd200);
        drain();
        chk("one_pass", 32'(score), 32'h0001);
        play_tick(12'd101, 12'd101, 12'd300, 1'b0, 12'd200);
        play_tick(12'd100, 12'd100, 12'd300, 1'b0, 12'd200);
        play_tick(12'd5,   12'd300, 12'd300, 1'b0, 12'd200);
        play_tick(12'd400, 12'd300, 12'd300, 1'b0, 12'd200);
        drain();
        chk("two_pass_wrap", 32'(score), 32'h0003);
        play_tick(12'd101, 12'd101, 12'd300, 1'b0, 12'd200);
        play_tick(12'd100, 12'd100, 12'd300, 1'b0, 12'd200);
        play_tick(12'd300, 12'd300, 12'd300, 1'b1, 12'd200);
        drain();
        chk("over1_best", 32'(best), 32'h0005);
        chk("over1_flag", 32'(game_over), 32'd1);
        chk("over1_run_en", 32'(run_en), 32'd0);

        // Press after two OVER ticks must be ignored.
        n_tk = 0;
        for (int i = 0; i < 40 && n_tk < 2; i++) begin
            @(negedge clk);
            if (frame_tick && game_over) n_tk++;
        end
        chk("hold_ticks", 32'(n_tk), 32'd2);
        btn_start = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (restart || flap) saw = 1'b1;
        end
        chk("hold_ignore", 32'(saw), 32'd0);
        chk("hold_state", 32'(state), 32'd2);
        btn_start = 1'b0;
        repeat (4) @(negedge clk);
        btn_start = 1'b1;
        wait_restart(got);
        chk("hold_restart", 32'(got), 32'd1);
        @(negedge clk);
        chk("rs1_state", 32'(state), 32'd1);
        chk("rs1_score", 32'(score), 32'd0);
        chk("rs1_best", 32'(best), 32'h0005);
        btn_start = 1'b0;
        m_restart();

        // Collision tick with a pending pass: no score, best updated.
        pump(2);
        play_tick(12'd101, 12'd300, 12'd300, 1'b0, 12'd200);
        play_tick(12'd100, 12'd300, 12'd300, 1'b0, 12'd200);
        play_tick(12'd101, 12'd300, 12'd300, 1'b0, 12'd200);
        play_tick(12'd100, 12'd300, 12'd300, 1'b1, 12'd200);
        drain();
        chk("hit_state", 32'(state), 32'd2);
        chk("hit_score", 32'(score), 32'h0007);
        chk("hit_best", 32'(best), 32'h0007);
        restart_over();

        // Hit between ticks has no effect.
        play_tick(12'd300, 12'd300, 12'd300, 1'b0, 12'd200);
        @(negedge clk); hit = 1'b1;
        @(negedge clk); hit = 1'b0;
        play_tick(12'd300, 12'd300, 12'd300, 1'b0, 12'd200);
        drain();
        chk("hit_between", 32'(state), 32'd1);

        pump(33);
        drain();
        chk("score_99", 32'(score), 32'h0099);
        play_tick(12'd101, 12'd300, 12'd300, 1'b0, 12'd200);
        play_tick(12'd100, 12'd300, 12'd300, 1'b0, 12'd200);
        drain();
        chk("score_100", 32'(score), 32'h0100);
        pump(3300);
        drain();
        chk("score_sat", 32'(score), 32'h9999);
        play_tick(12'd101, 12'd101, 12'd300, 1'b0, 12'd200);
        play_tick(12'd100, 12'd100, 12'd300, 1'b0, 12'd200);
        drain();
        chk("score_sat2", 32'(score), 32'h9999);

        // Floor collision.
        play_tick(12'd300, 12'd300, 12'd300, 1'b0, 12'd460);
        drain();
        chk("floor_state", 32'(state), 32'd2);
        chk("floor_best", 32'(best), 32'h9999);
        restart_over();

        // Async reset mid-PLAY.
        pump(4);
        drain();
        chk("pre_rst_score", 32'(score), 32'h0012);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_score", 32'(score), 32'd0);
        chk("arst_best", 32'(best), 32'd0);
        chk("arst_run_en", 32'(run_en), 32'd0);
        repeat (2) @(posedge clk);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
